// File: rtl/div_32_seq.sv
// div_32_seq
// ----------
// Multi-cycle integer divider for the EXP4 datapath (DIV / DIVU). It
// computes quotient and remainder by restoring shift-subtract, retiring
// one quotient bit per clock. The control unit stalls while busy is high
// and writes LO <= Q and HI <= R when done pulses.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-high
//   start    : request pulse, sampled only while idle
//   sign     : 1 = signed (DIV), 0 = unsigned (DIVU), latched with start
//   A        : dividend, latched with start
//   B        : divisor, latched with start
//   busy     : high while a request is in progress
//   done     : one-cycle pulse when Q/R/div_zero are valid
//   Q        : quotient (to LO)
//   R        : remainder (to HI)
//   div_zero : valid with done, 1 = divisor was zero
//
// Timing: start sampled at edge E0. The WIDTH iterations run on edges
// E1..E32, and the sign fix-up with the done pulse happens at E33. A zero
// divisor skips the iterations, so done rises at E1.

module div_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             sign_q;
    logic             a_neg;
    logic             b_neg;
    logic             zero_q;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             last_iter;

    // Magnitudes of the operands for signed requests. The most negative
    // value maps onto itself, which is the correct unsigned magnitude.
    // The remainder path is one bit wider than the operands, so a divisor
    // at or above 2^(WIDTH-1) never wraps. A clear top bit of the trial
    // difference means the subtraction did not borrow, so the quotient
    // bit is 1.
    always_comb begin
        a_abs     = A[WIDTH-1] ? -A : A;
        b_abs     = B[WIDTH-1] ? -B : B;
        rem_shift = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr};
        last_iter = (count == CW'(WIDTH - 1));
    end

    assign busy = (state != IDLE);

    // State register. A reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero divisor skips the iteration phase entirely
    // and goes straight to the result stage.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (B == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. On acceptance, dvd holds the magnitude of the dividend,
    // or the raw dividend when the divisor is zero, because that value is
    // returned unchanged as the remainder. During RUN, dvd shifts left
    // while quotient bits are shifted into its LSB, so after the last
    // iteration it holds the unsigned quotient. Q, R and div_zero update
    // only in FIX and hold their values otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            sign_q   <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            zero_q   <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            Q        <= '0;
            R        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= sign;
                        a_neg  <= A[WIDTH-1];
                        b_neg  <= B[WIDTH-1];
                        zero_q <= (B == '0);
                        rem    <= '0;
                        count  <= '0;
                        if (B == '0) begin
                            dvd <= A;
                        end else begin
                            dvd <= sign ? a_abs : A;
                        end
                        dsr <= sign ? b_abs : B;
                    end
                end
                RUN: begin
                    rem   <= trial[WIDTH] ? rem_shift : trial;
                    dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (zero_q) begin
                        Q        <= '1;
                        R        <= dvd;
                        div_zero <= 1'b1;
                    end else begin
                        Q        <= (sign_q && (a_neg != b_neg)) ? -dvd : dvd;
                        R        <= (sign_q && a_neg) ? -rem[WIDTH-1:0]
                                                      : rem[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
